// File: rtl/fx2_pkg.sv
// Shared types and FX2 pin constants for the slave-FIFO IN stream controller.
package fx2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        PEND  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // FIFOADR encodings for the four FX2 endpoint FIFOs
    localparam logic [1:0] EP2 = 2'b00;
    localparam logic [1:0] EP4 = 2'b01;
    localparam logic [1:0] EP6 = 2'b10;
    localparam logic [1:0] EP8 = 2'b11;

    localparam logic SLWR_INACTIVE   = 1'b1;
    localparam logic PKTEND_INACTIVE = 1'b1;

endpackage

// File: rtl/fx2_stream_in_ctrl_if.sv
// Upstream valid/ready word stream feeding the FX2 IN controller.
interface fx2_stream_in_ctrl_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              s_last;

    modport master (output s_data, output s_valid, output s_last, input  s_ready);
    modport slave  (input  s_data, input  s_valid, input  s_last, output s_ready);
endinterface

// File: rtl/fx2_pkt_counter.sv
// Per-packet word count with boundary detect, saturating idle timer, committed-packet count.
// Registered state; commit (PKTEND) and word transfer never coincide.
module fx2_pkt_counter #(
    parameter int PKT_LEN      = 512,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        xfer,
    input  logic        idle_tick,
    input  logic        commit,
    output logic        at_boundary,
    output logic        word_zero,
    output logic        timeout_hit,
    output logic [15:0] pkt_count
);
    localparam int WC_W = $clog2(PKT_LEN);
    localparam int IC_W = $clog2(IDLE_TIMEOUT + 2);
    localparam logic [WC_W-1:0] LAST_IDX = WC_W'(PKT_LEN - 1);
    localparam logic [IC_W-1:0] IDLE_MAX = IC_W'(IDLE_TIMEOUT);

    logic [WC_W-1:0] word_cnt;
    logic [IC_W-1:0] idle_cnt;

    assign at_boundary = (word_cnt == LAST_IDX);
    assign word_zero   = (word_cnt == '0);
    assign timeout_hit = (IDLE_TIMEOUT != 0) && (idle_cnt == IDLE_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt  <= '0;
            idle_cnt  <= '0;
            pkt_count <= '0;
        end else if (commit) begin
            word_cnt  <= '0;
            idle_cnt  <= '0;
            pkt_count <= pkt_count + 16'd1;
        end else if (xfer) begin
            idle_cnt <= '0;
            if (at_boundary) begin
                // full packet: FX2 auto-commits at AUTOINLEN
                word_cnt  <= '0;
                pkt_count <= pkt_count + 16'd1;
            end else begin
                word_cnt <= word_cnt + 1'b1;
            end
        end else if (idle_tick && idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fx2_stream_in_ctrl.sv
// Stream -> FX2 IN FIFO writer, 1-cycle latency to FD/SLWR#; s_ready = WRITE & flag_full_n, PKTEND# on short packets.
// Optional FX2_TEST_PATTERN_EN: pattern_sel=1 swaps the upstream stream for an internal counter.
module fx2_stream_in_ctrl
    import fx2_pkg::*;
#(
    parameter int         DATA_W       = 8,
    parameter int         PKT_LEN      = 512,
    parameter int         IDLE_TIMEOUT = 1024,
    parameter logic [1:0] FIFO_ADDR    = EP6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    fx2_stream_in_ctrl_if.slave  s,
    input  logic                 pattern_sel,
    input  logic                 flag_full_n,
    output logic [DATA_W-1:0]    fd,
    output logic [1:0]           faddr,
    output logic                 slwr_n,
    output logic                 slrd_n,
    output logic                 sloe_n,
    output logic                 pktend_n,
    output logic [15:0]          pkt_count
);
    state_t            state;
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_last;
    logic              s_ready;
    logic              xfer;
    logic              at_boundary;
    logic              word_zero;
    logic              timeout_hit;

`ifdef FX2_TEST_PATTERN_EN
    logic [DATA_W-1:0] pat_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            pat_cnt <= '0;
        else if (xfer && pattern_sel)
            pat_cnt <= pat_cnt + 1'b1;
    end

    assign src_data  = pattern_sel ? pat_cnt : s.s_data;
    assign src_valid = pattern_sel | s.s_valid;
    assign src_last  = ~pattern_sel & s.s_last;
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = pattern_sel;
    assign src_data  = s.s_data;
    assign src_valid = s.s_valid;
    assign src_last  = s.s_last;
`endif

    assign s_ready   = (state == WRITE) & flag_full_n;
    assign s.s_ready = s_ready;
    assign xfer      = src_valid & s_ready;
    assign faddr     = FIFO_ADDR;
    assign slrd_n    = 1'b1;
    assign sloe_n    = 1'b1;

    fx2_pkt_counter #(
        .PKT_LEN      (PKT_LEN),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) u_cnt (
        .clk         (clk),
        .reset       (reset),
        .xfer        (xfer),
        .idle_tick   (s_ready & ~xfer),
        .commit      (state == PEND),
        .at_boundary (at_boundary),
        .word_zero   (word_zero),
        .timeout_hit (timeout_hit),
        .pkt_count   (pkt_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fd       <= '0;
            slwr_n   <= SLWR_INACTIVE;
            pktend_n <= PKTEND_INACTIVE;
        end else begin
            slwr_n   <= xfer ? ~SLWR_INACTIVE : SLWR_INACTIVE;
            pktend_n <= PKTEND_INACTIVE;
            if (xfer)
                fd <= src_data;
            case (state)
                IDLE: if (enable) state <= WRITE;
                WRITE: begin
                    if (xfer && src_last && !at_boundary)
                        state <= PEND;
                    else if (xfer && src_last)
                        state <= enable ? WRITE : IDLE;   // frame ends on auto-commit: no ZLP
                    else if (!xfer && timeout_hit && !word_zero)
                        state <= PEND;
                    else if (!enable && (xfer ? at_boundary : word_zero))
                        state <= IDLE;
                end
                PEND: begin
                    // last SLWR# is on the bus now; PKTEND# follows next cycle
                    pktend_n <= ~PKTEND_INACTIVE;
                    state    <= GAP;
                end
                GAP:     state <= enable ? WRITE : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
